// File: rtl/clint_timer_if.sv
// Request/response bus between a single requester and the CLINT timer block.
// One request may be outstanding. The slave holds the response until the requester takes it.
interface clint_timer_if #(
  parameter int XLEN = 64
);
  logic              ReqValid;
  logic              ReqReady;
  logic              ReqWrite;
  logic [15:0]       ReqAdr;
  logic [XLEN-1:0]   ReqWData;
  logic [XLEN/8-1:0] ReqByteMask;
  logic              RspValid;
  logic              RspReady;
  logic [XLEN-1:0]   RspRData;
  logic              RspErr;

  modport master (
    output ReqValid, ReqWrite, ReqAdr, ReqWData, ReqByteMask, RspReady,
    input  ReqReady, RspValid, RspRData, RspErr
  );

  modport slave (
    input  ReqValid, ReqWrite, ReqAdr, ReqWData, ReqByteMask, RspReady,
    output ReqReady, RspValid, RspRData, RspErr
  );
endinterface

// File: rtl/clint_timer.sv
// Machine timer and software interrupt block for one hart.
// It holds the mtime, mtimecmp and msip registers behind a single-outstanding request/response bus.
//
// state  | meaning
// S_IDLE | ReqReady high; an incoming request is accepted here
// S_RESP | response registered; held until RspReady
module clint_timer #(
  parameter int XLEN         = 64,
  parameter int TIMEBASE_DIV = 1
) (
  input  logic         clk,
  input  logic         reset,
  clint_timer_if.slave bus,
  output logic [63:0]  MTIME_CLINT,
  output logic         MTimerInt,
  output logic         MSwInt
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [63:0]     mtime_q, mtime_d;
  logic [63:0]     mtimecmp_q, mtimecmp_d;
  logic            msip_q, msip_d;
  logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;
  logic            tick;

  function automatic logic [63:0] merge_bytes(input logic [63:0] old_v,
                                              input logic [63:0] new_v,
                                              input logic [7:0]  be);
    logic [63:0] r;
    r = old_v;
    for (int i = 0; i < 8; i++) begin
      if (be[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
    end
    return r;
  endfunction

  // mtime advances every cycle when the divider is 1, so no counter is needed then
  if (TIMEBASE_DIV == 1) begin : g_nodiv
    assign tick = 1'b1;
  end else begin : g_div
    localparam int            PW   = $clog2(TIMEBASE_DIV);
    localparam logic [PW-1:0] LAST = PW'(TIMEBASE_DIV - 1);
    logic [PW-1:0] presc_q, presc_d;

    assign tick    = (presc_q == LAST);
    assign presc_d = tick ? '0 : presc_q + 1'b1;

    always_ff @(posedge clk) begin
      if (reset) presc_q <= '0;
      else       presc_q <= presc_d;
    end
  end

  logic accept, misaligned, dec_err, wr_ok;
  logic hit_msip, hit_cmp_lo, hit_cmp_hi, hit_time_lo, hit_time_hi;

  assign accept      = bus.ReqValid && (state_q == S_IDLE);
  assign misaligned  = (XLEN == 64) ? (bus.ReqAdr[2:0] != 3'b000) : (bus.ReqAdr[1:0] != 2'b00);
  assign hit_msip    = (bus.ReqAdr == 16'h0000);
  assign hit_cmp_lo  = (bus.ReqAdr == 16'h4000);
  assign hit_cmp_hi  = (XLEN == 32) && (bus.ReqAdr == 16'h4004);
  assign hit_time_lo = (bus.ReqAdr == 16'hBFF8);
  assign hit_time_hi = (XLEN == 32) && (bus.ReqAdr == 16'hBFFC);
  assign dec_err     = misaligned ||
                       !(hit_msip || hit_cmp_lo || hit_cmp_hi || hit_time_lo || hit_time_hi);
  assign wr_ok       = accept && bus.ReqWrite && !dec_err;

  // Place bus data and byte enables onto the 64-bit register lanes
  logic [63:0] wdata_ext;
  logic [7:0]  be_lo, be_hi;

  if (XLEN == 64) begin : g_x64
    assign wdata_ext = bus.ReqWData;
    assign be_lo     = bus.ReqByteMask;
    assign be_hi     = 8'h00;
  end else begin : g_x32
    assign wdata_ext = {bus.ReqWData, bus.ReqWData};
    assign be_lo     = {4'b0000, bus.ReqByteMask};
    assign be_hi     = {bus.ReqByteMask, 4'b0000};
  end

  logic [7:0]  cmp_be, time_be;
  logic [63:0] rd_word;

  assign cmp_be  = !wr_ok ? 8'h00 : hit_cmp_lo  ? be_lo : hit_cmp_hi  ? be_hi : 8'h00;
  assign time_be = !wr_ok ? 8'h00 : hit_time_lo ? be_lo : hit_time_hi ? be_hi : 8'h00;

  always_comb begin
    rd_word = 64'd0;
    if (hit_msip)         rd_word = {63'd0, msip_q};
    else if (hit_cmp_lo)  rd_word = mtimecmp_q;
    else if (hit_cmp_hi)  rd_word = {32'd0, mtimecmp_q[63:32]};
    else if (hit_time_lo) rd_word = mtime_q;
    else if (hit_time_hi) rd_word = {32'd0, mtime_q[63:32]};
  end

  // A write to either mtime half suppresses that cycle's increment for the whole register
  always_comb begin
    msip_d = msip_q;
    if (wr_ok && hit_msip && be_lo[0]) msip_d = wdata_ext[0];

    mtimecmp_d = merge_bytes(mtimecmp_q, wdata_ext, cmp_be);

    if (time_be != 8'h00) mtime_d = merge_bytes(mtime_q, wdata_ext, time_be);
    else if (tick)        mtime_d = mtime_q + 64'd1;
    else                  mtime_d = mtime_q;

    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if (accept) begin
      rsp_err_d   = dec_err;
      rsp_rdata_d = (bus.ReqWrite || dec_err) ? '0 : rd_word[XLEN-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mtime_q     <= 64'd0;
      mtimecmp_q  <= '1;
      msip_q      <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      msip_q      <= msip_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.ReqValid) state_d = S_RESP;
      S_RESP:  if (bus.RspReady) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.ReqReady = 1'b0;
    bus.RspValid = 1'b0;
    case (state_q)
      S_IDLE:  bus.ReqReady = 1'b1;
      S_RESP:  bus.RspValid = 1'b1;
      default: bus.ReqReady = 1'b0;
    endcase
  end

  assign bus.RspRData = rsp_rdata_q;
  assign bus.RspErr   = rsp_err_q;
  assign MTIME_CLINT  = mtime_q;
  assign MTimerInt    = (mtime_q >= mtimecmp_q);
  assign MSwInt       = msip_q;

endmodule

// File: tb/tb_clint_timer.sv
// Bench for clint_timer: one XLEN=64/div-1 instance and one XLEN=32/div-4 instance.
// A register-map model predicts every output on every cycle.
module tb_clint_timer;
  localparam int unsigned DIV0 = 1;
  localparam int unsigned DIV1 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [2];
  logic        req_valid [2];
  logic        req_write [2];
  logic [15:0] req_adr   [2];
  logic [63:0] req_wdata [2];
  logic [7:0]  req_mask  [2];
  logic        rsp_ready [2];

  logic [63:0] o_mtime  [2];
  logic [63:0] o_rdata  [2];
  logic        o_ti     [2];
  logic        o_sw     [2];
  logic        o_ready  [2];
  logic        o_rvalid [2];
  logic        o_err    [2];

  clint_timer_if #(.XLEN(64)) bus0 ();
  clint_timer_if #(.XLEN(32)) bus1 ();

  assign bus0.ReqValid    = req_valid[0];
  assign bus0.ReqWrite    = req_write[0];
  assign bus0.ReqAdr      = req_adr[0];
  assign bus0.ReqWData    = req_wdata[0];
  assign bus0.ReqByteMask = req_mask[0];
  assign bus0.RspReady    = rsp_ready[0];
  assign bus1.ReqValid    = req_valid[1];
  assign bus1.ReqWrite    = req_write[1];
  assign bus1.ReqAdr      = req_adr[1];
  assign bus1.ReqWData    = req_wdata[1][31:0];
  assign bus1.ReqByteMask = req_mask[1][3:0];
  assign bus1.RspReady    = rsp_ready[1];

  assign o_rdata[0]  = bus0.RspRData;
  assign o_rdata[1]  = {32'd0, bus1.RspRData};
  assign o_ready[0]  = bus0.ReqReady;
  assign o_ready[1]  = bus1.ReqReady;
  assign o_rvalid[0] = bus0.RspValid;
  assign o_rvalid[1] = bus1.RspValid;
  assign o_err[0]    = bus0.RspErr;
  assign o_err[1]    = bus1.RspErr;

  clint_timer #(.XLEN(64), .TIMEBASE_DIV(DIV0)) u_dut0 (
    .clk(clk), .reset(rst[0]), .bus(bus0),
    .MTIME_CLINT(o_mtime[0]), .MTimerInt(o_ti[0]), .MSwInt(o_sw[0])
  );

  clint_timer #(.XLEN(32), .TIMEBASE_DIV(DIV1)) u_dut1 (
    .clk(clk), .reset(rst[1]), .bus(bus1),
    .MTIME_CLINT(o_mtime[1]), .MTimerInt(o_ti[1]), .MSwInt(o_sw[1])
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [63:0] m_mtime [2];
  logic [63:0] m_cmp   [2];
  logic        m_msip  [2];
  int unsigned m_cyc   [2];
  logic        m_resp  [2];
  logic [63:0] m_rdata [2];
  logic        m_err   [2];
  logic        started [2] = '{1'b0, 1'b0};

  function automatic logic [63:0] apply_mask(input logic [63:0] old_v, input logic [63:0] new_v,
                                             input logic [7:0] be);
    logic [63:0] m;
    for (int i = 0; i < 64; i++) m[i] = be[i/8];
    return (old_v & ~m) | (new_v & m);
  endfunction

  task automatic model_step(input int d);
    logic [63:0] nt, nc, rd, wd;
    logic [7:0]  mk;
    logic [15:0] a;
    logic        nm, er, tick, twr, wr;
    int unsigned div;
    div = (d == 0) ? DIV0 : DIV1;
    if (rst[d]) begin
      m_mtime[d] = 64'd0; m_cmp[d] = '1; m_msip[d] = 1'b0; m_cyc[d] = 0;
      m_resp[d] = 1'b0; m_rdata[d] = 64'd0; m_err[d] = 1'b0; started[d] = 1'b1;
      return;
    end
    tick = ((m_cyc[d] % div) == div - 1);
    m_cyc[d]++;
    nt = m_mtime[d]; nc = m_cmp[d]; nm = m_msip[d]; twr = 1'b0;
    if (m_resp[d]) begin
      if (rsp_ready[d]) m_resp[d] = 1'b0;
    end else if (req_valid[d]) begin
      a = req_adr[d]; wd = req_wdata[d]; mk = req_mask[d]; wr = req_write[d];
      rd = 64'd0; er = 1'b0;
      if (d == 0) begin
        if (a[2:0] != 3'd0) er = 1'b1;
        else if (a == 16'h0000) begin rd = {63'd0, m_msip[d]}; if (wr && mk[0]) nm = wd[0]; end
        else if (a == 16'h4000) begin rd = m_cmp[d]; if (wr) nc = apply_mask(m_cmp[d], wd, mk); end
        else if (a == 16'hBFF8) begin
          rd = m_mtime[d];
          if (wr) begin nt = apply_mask(m_mtime[d], wd, mk); twr = (mk != 8'd0); end
        end else er = 1'b1;
      end else begin
        mk = {4'd0, mk[3:0]}; wd = {32'd0, wd[31:0]};
        if (a[1:0] != 2'd0) er = 1'b1;
        else if (a == 16'h0000) begin rd = {63'd0, m_msip[d]}; if (wr && mk[0]) nm = wd[0]; end
        else if (a == 16'h4000) begin rd = {32'd0, m_cmp[d][31:0]}; if (wr) nc = apply_mask(m_cmp[d], wd, mk); end
        else if (a == 16'h4004) begin rd = {32'd0, m_cmp[d][63:32]}; if (wr) nc = apply_mask(m_cmp[d], wd << 32, mk << 4); end
        else if (a == 16'hBFF8) begin
          rd = {32'd0, m_mtime[d][31:0]};
          if (wr) begin nt = apply_mask(m_mtime[d], wd, mk); twr = (mk != 8'd0); end
        end else if (a == 16'hBFFC) begin
          rd = {32'd0, m_mtime[d][63:32]};
          if (wr) begin nt = apply_mask(m_mtime[d], wd << 32, mk << 4); twr = (mk != 8'd0); end
        end else er = 1'b1;
      end
      if (wr || er) rd = 64'd0;
      m_resp[d] = 1'b1; m_rdata[d] = rd; m_err[d] = er;
    end
    if (!twr && tick) nt = m_mtime[d] + 64'd1;
    m_mtime[d] = nt; m_cmp[d] = nc; m_msip[d] = nm;
  endtask

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) model_step(d);
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (started[d]) begin
        check($sformatf("d%0d_mtime", d), o_mtime[d], m_mtime[d]);
        check1($sformatf("d%0d_timer_int", d), o_ti[d], (m_mtime[d] >= m_cmp[d]));
        check1($sformatf("d%0d_sw_int", d), o_sw[d], m_msip[d]);
        check1($sformatf("d%0d_req_ready", d), o_ready[d], !m_resp[d]);
        check1($sformatf("d%0d_rsp_valid", d), o_rvalid[d], m_resp[d]);
        if (m_resp[d]) begin
          check($sformatf("d%0d_rsp_rdata", d), o_rdata[d], m_rdata[d]);
          check1($sformatf("d%0d_rsp_err", d), o_err[d], m_err[d]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick_n(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic xact(input int d, input logic wr, input logic [15:0] adr, input logic [63:0] wd,
                      input logic [7:0] mk, input int hold,
                      output logic [63:0] rd, output logic er);
    int budget;
    req_valid[d] = 1'b1; req_write[d] = wr; req_adr[d] = adr;
    req_wdata[d] = wd; req_mask[d] = mk;
    budget = 0;
    while (!o_ready[d] && budget < 20) begin tick_n(1); budget++; end
    if (!o_ready[d]) begin
      n_checks++; n_fail++;
      $display("FAIL d%0d_accept_timeout: ReqReady got 0, expected 1", d);
      req_valid[d] = 1'b0; rd = '0; er = 1'b1;
      return;
    end
    tick_n(1);
    req_valid[d] = 1'b0;
    rsp_ready[d] = 1'b0;
    check1($sformatf("d%0d_rsp_latency", d), o_rvalid[d], 1'b1);
    tick_n(hold);
    rsp_ready[d] = 1'b1;
    rd = o_rdata[d]; er = o_err[d];
    tick_n(1);
    rsp_ready[d] = 1'b0;
  endtask

  logic [15:0] alist [10] = '{16'h0000, 16'h4000, 16'h4004, 16'hBFF8, 16'hBFFC,
                              16'h0010, 16'h4001, 16'hBFFA, 16'h0004, 16'h4002};

  initial begin
    logic [63:0] rd;
    logic        er;
    int          budget;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req_valid[d] = 1'b0; req_write[d] = 1'b0; req_adr[d] = 16'h0;
      req_wdata[d] = 64'd0; req_mask[d] = 8'd0; rsp_ready[d] = 1'b0;
    end
    tick_n(2);
    rst[0] = 1'b0; rst[1] = 1'b0;

    // ----- 64-bit instance, divider 1 -----
    tick_n(10);
    check("idle10_mtime", o_mtime[0], 64'd10);
    check1("idle10_timer_int", o_ti[0], 1'b0);
    check1("idle10_sw_int", o_sw[0], 1'b0);
    check1("idle10_req_ready", o_ready[0], 1'b1);

    xact(0, 1'b1, 16'h4000, 64'h20, 8'hFF, 0, rd, er);
    check("cmp_wr_ack_data", rd, 64'd0);
    budget = 0;
    while (o_mtime[0] != 64'h20 && budget < 100) begin
      check1("timer_int_below_cmp", o_ti[0], 1'b0);
      tick_n(1); budget++;
    end
    check("mtime_reaches_cmp", o_mtime[0], 64'h20);
    check1("timer_int_at_cmp", o_ti[0], 1'b1);
    xact(0, 1'b1, 16'h4000, 64'h100, 8'hFF, 0, rd, er);
    check1("timer_int_after_raise", o_ti[0], 1'b0);

    xact(0, 1'b1, 16'h0000, 64'hFFFF_FFFF, 8'hFF, 1, rd, er);
    check1("msip_sw_int", o_sw[0], 1'b1);
    xact(0, 1'b0, 16'h0000, 64'd0, 8'hFF, 0, rd, er);
    check("msip_read_data", rd, 64'd1);
    check1("msip_read_err", er, 1'b0);

    xact(0, 1'b0, 16'h0010, 64'd0, 8'hFF, 0, rd, er);
    check1("unmapped_err", er, 1'b1);
    check("unmapped_data", rd, 64'd0);
    xact(0, 1'b0, 16'h4001, 64'd0, 8'hFF, 2, rd, er);
    check1("misaligned_err", er, 1'b1);
    check("misaligned_data", rd, 64'd0);
    xact(0, 1'b1, 16'h4004, 64'd5, 8'hFF, 0, rd, er);
    check1("misaligned_wr_err", er, 1'b1);
    xact(0, 1'b0, 16'h4000, 64'd0, 8'h00, 0, rd, er);
    check("cmp_unchanged", rd, 64'h100);

    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_adr[0] = 16'h4000;
    tick_n(1);
    req_adr[0] = 16'hBFF8;
    for (int i = 0; i < 5; i++) begin
      check1("stall_rsp_valid", o_rvalid[0], 1'b1);
      check("stall_rsp_rdata", o_rdata[0], 64'h100);
      check1("stall_req_ready", o_ready[0], 1'b0);
      tick_n(1);
    end
    req_valid[0] = 1'b0;
    rst[0] = 1'b1;
    tick_n(1);
    rst[0] = 1'b0;
    check1("reset_in_resp_valid", o_rvalid[0], 1'b0);
    check1("reset_in_resp_ready", o_ready[0], 1'b1);
    check("reset_in_resp_mtime", o_mtime[0], 64'd0);

    // ----- 32-bit instance, divider 4 -----
    rst[1] = 1'b1; tick_n(1); rst[1] = 1'b0;
    tick_n(12);
    check("div4_12cyc_mtime", o_mtime[1], 64'd3);

    rst[1] = 1'b1; tick_n(1); rst[1] = 1'b0;
    tick_n(7);
    req_valid[1] = 1'b1; req_write[1] = 1'b1; req_adr[1] = 16'hBFF8;
    req_wdata[1] = 64'd0; req_mask[1] = 8'h0F;
    tick_n(1);
    req_valid[1] = 1'b0; rsp_ready[1] = 1'b1;
    tick_n(1);
    rsp_ready[1] = 1'b0;
    tick_n(3);
    check("div4_write_on_tick_mtime", o_mtime[1], 64'd1);

    xact(1, 1'b1, 16'hBFFC, 64'd0, 8'h0F, 0, rd, er);
    xact(1, 1'b1, 16'hBFF8, 64'hFFFF_FFFF, 8'h0F, 0, rd, er);
    budget = 0;
    while (o_mtime[1] == 64'h0000_0000_FFFF_FFFF && budget < 10) begin tick_n(1); budget++; end
    check("x32_carry_into_high", o_mtime[1], 64'h1_0000_0000);

    budget = 0;
    while ((m_cyc[1] % DIV1) != DIV1 - 1 && budget < 10) begin tick_n(1); budget++; end
    req_valid[1] = 1'b1; req_write[1] = 1'b1; req_adr[1] = 16'hBFF8;
    req_wdata[1] = 64'd5; req_mask[1] = 8'h0F;
    tick_n(1);
    check("x32_low_write_on_tick", o_mtime[1], 64'h1_0000_0005);
    req_valid[1] = 1'b0; rsp_ready[1] = 1'b1;
    tick_n(1);
    rsp_ready[1] = 1'b0;

    xact(1, 1'b0, 16'h4004, 64'd0, 8'h0F, 0, rd, er);
    check("x32_cmp_hi_reset", rd, 64'hFFFF_FFFF);
    xact(1, 1'b0, 16'h4002, 64'd0, 8'h0F, 0, rd, er);
    check1("x32_misaligned_err", er, 1'b1);

    // ----- randomized traffic on both instances, checked by the model -----
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 150; n++) begin
        logic [15:0] a;
        logic [63:0] wd;
        int gap;
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
          rsp_ready[d] = 1'($urandom_range(0, 1));
          tick_n(1);
        end
        if ($urandom_range(0, 39) == 0) begin
          rst[d] = 1'b1; tick_n(1); rst[d] = 1'b0;
        end
        a  = ($urandom_range(0, 9) == 0) ? 16'($urandom) : alist[$urandom_range(0, 9)];
        wd = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 600));
        xact(d, 1'($urandom_range(0, 1)), a, wd, 8'($urandom_range(1, 255)),
             $urandom_range(0, 3), rd, er);
      end
    end

    tick_n(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
